// File: rtl/conv_cnn_accel.sv
// 3x3 conv + bias + ReLU over a 64x64 image, 2x2 max-pool, interleaved flatten.
// Sliding column window feeds one fully parallel MAC per pixel.
module conv_cnn_accel (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [11:0] iaddr,
  input  logic [19:0] idata,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_L0END = 3'd3;
  localparam logic [2:0] S_L1    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [19:0] B0 = 20'h01310;
  localparam logic [19:0] B1 = 20'hF7295;

  function automatic logic signed [19:0] f_k(
    input logic       k,
    input logic [3:0] i
  );
    logic [19:0] v;
    case ({k, i})
      5'h00:   v = 20'h0A89E;
      5'h01:   v = 20'h092D5;
      5'h02:   v = 20'h06D43;
      5'h03:   v = 20'h01004;
      5'h04:   v = 20'hF8F71;
      5'h05:   v = 20'hF6E54;
      5'h06:   v = 20'hFA6D7;
      5'h07:   v = 20'hFC834;
      5'h08:   v = 20'hFAC19;
      5'h10:   v = 20'hFDB55;
      5'h11:   v = 20'h02992;
      5'h12:   v = 20'hFC994;
      5'h13:   v = 20'h050FD;
      5'h14:   v = 20'h02F20;
      5'h15:   v = 20'h0202D;
      5'h16:   v = 20'h03BD7;
      5'h17:   v = 20'hFD369;
      5'h18:   v = 20'h05E68;
      default: v = 20'h00000;
    endcase
    return signed'(v);
  endfunction

  function automatic logic signed [43:0] f_term(
    input logic signed [19:0] k,
    input logic signed [19:0] v
  );
    logic signed [39:0] p;
    p = k * v;
    return {{4{p[39]}}, p};
  endfunction

  logic [2:0]         r_state;
  logic [2:0]         r_ph;
  logic [5:0]         r_y;
  logic [5:0]         r_x;
  logic [6:0]         r_cx;
  logic signed [19:0] r_win [9];
  logic [19:0]        r_n0;
  logic [19:0]        r_n1;
  logic               r_ivld;
  logic [19:0]        r_res1;
  logic               r_pend;
  logic               r_k;
  logic [9:0]         r_oi;
  logic signed [19:0] r_max;

  logic [6:0]         w_ry;
  logic               w_fvld;
  logic [19:0]        w_inpix;
  logic signed [43:0] w_acc0;
  logic signed [43:0] w_acc1;
  logic [19:0]        w_q0;
  logic [19:0]        w_q1;
  logic [19:0]        w_relu0;
  logic [19:0]        w_relu1;
  logic [19:0]        w_mx;
  logic               w_unused;

  // row under fetch wraps to 127 above the image, so one compare covers both edges
  assign w_ry    = {1'b0, r_y} + {5'b0, r_ph[1:0]} - 7'd1;
  assign w_fvld  = (w_ry < 7'd64) && !r_cx[6];
  assign w_inpix = r_ivld ? idata : 20'h00000;

  always_comb begin
    w_acc0 = {{8{B0[19]}}, B0, 16'h0000} + 44'h8000;
    w_acc1 = {{8{B1[19]}}, B1, 16'h0000} + 44'h8000;
    for (int i = 0; i < 9; i++) begin
      w_acc0 = w_acc0 + f_term(f_k(1'b0, 4'(i)), r_win[i]);
      w_acc1 = w_acc1 + f_term(f_k(1'b1, 4'(i)), r_win[i]);
    end
  end

  assign w_q0     = w_acc0[35:16];
  assign w_q1     = w_acc1[35:16];
  assign w_relu0  = w_q0[19] ? 20'h00000 : w_q0;
  assign w_relu1  = w_q1[19] ? 20'h00000 : w_q1;
  assign w_mx     = ($signed(cdata_rd) > r_max) ? cdata_rd : r_max;
  assign w_unused = ^{w_acc0[43:36], w_acc0[15:0],
                      w_acc1[43:36], w_acc1[15:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      busy     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'b000;
      iaddr    <= 12'd0;
      caddr_rd <= 12'd0;
      caddr_wr <= 12'd0;
      cdata_wr <= 20'd0;
      r_ph     <= 3'd0;
      r_y      <= 6'd0;
      r_x      <= 6'd0;
      r_cx     <= 7'd0;
      r_ivld   <= 1'b0;
      r_n0     <= 20'd0;
      r_n1     <= 20'd0;
      r_res1   <= 20'd0;
      r_pend   <= 1'b0;
      r_k      <= 1'b0;
      r_oi     <= 10'd0;
      r_max    <= 20'sd0;
      for (int i = 0; i < 9; i++) r_win[i] <= 20'sd0;
    end else begin
      cwr    <= 1'b0;
      crd    <= 1'b0;
      csel   <= 3'b000;
      r_pend <= 1'b0;
      // K1 result trails its K0 partner by one cycle
      if (r_pend) begin
        cwr      <= 1'b1;
        csel     <= 3'b010;
        cdata_wr <= r_res1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (ready) begin
            busy    <= 1'b1;
            r_state <= S_FETCH;
            r_y     <= 6'd0;
            r_x     <= 6'd0;
            r_cx    <= 7'd0;
            r_ph    <= 3'd0;
            for (int i = 0; i < 9; i++) r_win[i] <= 20'sd0;
          end
        end
        S_FETCH: begin
          if (r_ph != 3'd3) begin
            r_ivld <= w_fvld;
            if (w_fvld) iaddr <= {w_ry[5:0], r_cx[5:0]};
          end
          if (r_ph == 3'd1) r_n0 <= w_inpix;
          if (r_ph == 3'd2) r_n1 <= w_inpix;
          if (r_ph == 3'd3) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= r_n0;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= r_n1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= w_inpix;
            r_cx     <= r_cx + 7'd1;
            r_ph     <= 3'd0;
            // column 0 only primes the window; column 1 completes it
            if (r_cx != 7'd0) r_state <= S_CALC;
          end else begin
            r_ph <= r_ph + 3'd1;
          end
        end
        S_CALC: begin
          cwr      <= 1'b1;
          csel     <= 3'b001;
          caddr_wr <= {r_y, r_x};
          cdata_wr <= w_relu0;
          r_res1   <= w_relu1;
          r_pend   <= 1'b1;
          r_x      <= r_x + 6'd1;
          if (r_x == 6'd63) begin
            r_y  <= r_y + 6'd1;
            r_cx <= 7'd0;
            for (int i = 0; i < 9; i++) r_win[i] <= 20'sd0;
          end
          if (r_x == 6'd63 && r_y == 6'd63) r_state <= S_L0END;
          else r_state <= S_FETCH;
        end
        S_L0END: begin
          r_state <= S_L1;
          r_k     <= 1'b0;
          r_oi    <= 10'd0;
          r_ph    <= 3'd0;
        end
        S_L1: begin
          if (r_ph < 3'd4) begin
            crd      <= 1'b1;
            csel     <= r_k ? 3'b010 : 3'b001;
            caddr_rd <= {r_oi[9:5], r_ph[1], r_oi[4:0], r_ph[0]};
          end
          if (r_ph == 3'd1) r_max <= cdata_rd;
          else if (r_ph >= 3'd2 && r_ph <= 3'd4) r_max <= w_mx;
          if (r_ph == 3'd4) begin
            cwr      <= 1'b1;
            csel     <= r_k ? 3'b100 : 3'b011;
            caddr_wr <= {2'b00, r_oi};
            cdata_wr <= w_mx;
          end
          if (r_ph == 3'd5) begin
            cwr      <= 1'b1;
            csel     <= 3'b101;
            caddr_wr <= {1'b0, r_oi, r_k};
            r_ph     <= 3'd0;
            r_oi     <= r_oi + 10'd1;
            if (r_oi == 10'd1023) begin
              r_k <= ~r_k;
              if (r_k) r_state <= S_DONE;
            end
          end else begin
            r_ph <= r_ph + 3'd1;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_cnn_accel.sv
// Random-image bench for conv_cnn_accel with an arithmetic reference model.
// ROM and 5-bank RAM are modelled here; results are compared bank by bank.
module tb_conv_cnn_accel;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  conv_cnn_accel dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  logic [19:0] img [4096];
  logic [19:0] mem [5][4096];
  int          wcnt [5][4096];
  int          bad_wr;
  logic [19:0] e0 [2][4096];
  logic [19:0] e1 [2][1024];
  logic [19:0] e2 [2048];
  logic [19:0] kt [2][9];
  logic [19:0] bt [2];

  int n_chk  = 0;
  int n_fail = 0;
  int falls  = 0;
  int post   = 0;
  logic busy_q = 1'b0;

  assign idata = img[iaddr];
  assign cdata_rd = (crd && csel >= 3'd1 && csel <= 3'd5) ?
                    mem[csel - 3'd1][caddr_rd] : 20'h00000;

  always @(negedge clk) begin
    if (cwr) begin
      if (csel >= 3'd1 && csel <= 3'd5) begin
        automatic int b   = int'(csel) - 1;
        automatic int lim = (b < 2) ? 4096 : ((b < 4) ? 1024 : 2048);
        if (int'(caddr_wr) < lim) begin
          mem[b][caddr_wr] = cdata_wr;
          wcnt[b][caddr_wr]++;
        end else begin
          bad_wr++;
        end
      end else begin
        bad_wr++;
      end
    end
    if (busy_q && !busy) falls++;
    if (!busy && falls > 0 && (cwr || crd)) post++;
    busy_q = busy;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [19:0] v);
    return longint'(signed'(v));
  endfunction

  task automatic model();
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        for (int k = 0; k < 2; k++) begin
          automatic longint acc = (sx(bt[k]) <<< 16) + 64'sh8000;
          automatic logic [63:0] u;
          automatic logic [19:0] q;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              automatic int yy = y + dy;
              automatic int xx = x + dx;
              if (yy >= 0 && yy < 64 && xx >= 0 && xx < 64)
                acc += sx(kt[k][(dy + 1) * 3 + dx + 1]) * sx(img[yy * 64 + xx]);
            end
          u = acc;
          q = u[35:16];
          e0[k][y * 64 + x] = q[19] ? 20'h0 : q;
        end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          automatic logic [19:0] m = e0[k][(2 * r) * 64 + 2 * c];
          automatic logic [19:0] v [4];
          v[0] = e0[k][(2 * r) * 64 + 2 * c + 1];
          v[1] = e0[k][(2 * r + 1) * 64 + 2 * c];
          v[2] = e0[k][(2 * r + 1) * 64 + 2 * c + 1];
          v[3] = m;
          for (int j = 0; j < 3; j++)
            if (sx(v[j]) > sx(m)) m = v[j];
          e1[k][r * 32 + c] = m;
          e2[2 * (r * 32 + c) + k] = m;
        end
  endtask

  function automatic logic [19:0] expv(input int b, input int a);
    case (b)
      0:       return e0[0][a];
      1:       return e0[1][a];
      2:       return e1[0][a];
      3:       return e1[1][a];
      default: return e2[a];
    endcase
  endfunction

  task automatic clear_mem();
    for (int b = 0; b < 5; b++)
      for (int a = 0; a < 4096; a++) begin
        mem[b][a]  = 20'h0;
        wcnt[b][a] = 0;
      end
    bad_wr = 0;
    falls  = 0;
    post   = 0;
  endtask

  task automatic cmp_bank(input string nm, input int b);
    automatic int n   = (b < 2) ? 4096 : ((b < 4) ? 1024 : 2048);
    automatic int bad = -1;
    for (int a = 0; a < n; a++)
      if (bad < 0 && mem[b][a] !== expv(b, a)) bad = a;
    if (bad < 0) bad = 0;
    chk($sformatf("%s bank%0d[%0d]", nm, b + 1, bad), 64'(mem[b][bad]),
        64'(expv(b, bad)));
  endtask

  task automatic run_job(input string nm, input bit poke);
    automatic int n;
    automatic int nbad;
    clear_mem();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n = 1;
    while (!busy && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " busy_rise"}, 64'(n <= 2), 64'd1);
    n = 0;
    while (busy && n < 50000) begin
      @(negedge clk);
      n++;
      if (poke && n == 5000) ready = 1'b1;
      if (n == 5001) ready = 1'b0;
    end
    chk({nm, " done_in_time"}, 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    chk({nm, " busy_falls"}, 64'(falls), 64'd1);
    chk({nm, " post_pulses"}, 64'(post), 64'd0);
    chk({nm, " idle_outs"}, {59'd0, cwr, crd, csel}, 64'd0);
    nbad = bad_wr;
    for (int b = 0; b < 5; b++)
      for (int a = 0; a < ((b < 2) ? 4096 : ((b < 4) ? 1024 : 2048)); a++)
        if (wcnt[b][a] != 1) nbad++;
    chk({nm, " write_once"}, 64'(nbad), 64'd0);
    for (int b = 0; b < 5; b++) cmp_bank(nm, b);
  endtask

  initial begin
    kt[0] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
              20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
    kt[1] = '{20'hFDB55, 20'h02992, 20'hFC994, 20'h050FD, 20'h02F20,
              20'h0202D, 20'h03BD7, 20'hFD369, 20'h05E68};
    bt[0] = 20'h01310;
    bt[1] = 20'hF7295;
    for (int a = 0; a < 4096; a++) img[a] = 20'h0;
    clear_mem();
    reset = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {2'd0, busy, crd, cwr, csel, iaddr, caddr_rd,
                        caddr_wr, cdata_wr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // zero top half with one 0.5 pixel, uniform 1.0 bottom half
    for (int a = 0; a < 4096; a++) img[a] = (a >= 2048) ? 20'h10000 : 20'h0;
    img[65] = 20'h08000;
    model();
    run_job("imgA", 1'b1);
    chk("l0k0_129", 64'(mem[0][129]), 64'h05C7B);
    chk("l0k0_66", 64'(mem[0][66]), 64'h01B12);
    chk("l1k0_32", 64'(mem[2][32]), 64'h05C7B);
    chk("l2_64", 64'(mem[4][64]), 64'h05C7B);
    chk("uni_l0k1", 64'(mem[1][3104]), 64'h04F02);
    chk("uni_l0k0", 64'(mem[0][3104]), 64'h00000);
    chk("corner_l0k1", 64'(mem[1][4095]), 64'h00000);
    chk("bias_l0k0", 64'(mem[0][670]), 64'h01310);
    chk("bias_l0k1", 64'(mem[1][670]), 64'h00000);
    chk("bias_l1k0", 64'(mem[2][175]), 64'h01310);
    chk("bias_l2_even", 64'(mem[4][350]), 64'h01310);
    chk("bias_l2_odd", 64'(mem[4][351]), 64'h00000);

    for (int a = 0; a < 4096; a++) img[a] = 20'($urandom);
    model();
    clear_mem();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_drop", {58'd0, busy, cwr, crd, csel}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_job("imgB", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
